// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and default sizing for the mac_seq_ctrl dot-product sequencer.
package mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } state_t;

  localparam int unsigned INW_DEF  = 16;
  localparam int unsigned OUTW_DEF = 48;
  localparam int unsigned MAXK_DEF = 64;

endpackage

// File: rtl/mac_seq_ctrl_mac.sv
// Signed multiply-accumulate with a saturating accumulator and synchronous active-high reset.
module mac #(
  parameter int unsigned INW  = 16,
  parameter int unsigned OUTW = 48
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [INW-1:0]  in0,
  input  logic [INW-1:0]  in1,
  input  logic            valid_input,
  input  logic            clear_acc,
  output logic [OUTW-1:0] out
);

  localparam logic [OUTW-1:0] ACC_MAX = {1'b0, {(OUTW-1){1'b1}}};
  localparam logic [OUTW-1:0] ACC_MIN = {1'b1, {(OUTW-1){1'b0}}};

  logic signed [2*INW-1:0] prod;
  logic signed [OUTW:0]    sum;
  logic signed [OUTW-1:0]  acc_q, acc_d;

  assign prod = (2*INW)'($signed(in0)) * (2*INW)'($signed(in1));
  // One guard bit: disagreement between the top two bits of sum means overflow.
  assign sum  = (OUTW+1)'(acc_q) + (OUTW+1)'(prod);

  always_comb begin
    acc_d = acc_q;
    if (clear_acc) begin
      acc_d = '0;
    end else if (valid_input) begin
      if (sum[OUTW] != sum[OUTW-1]) begin
        acc_d = sum[OUTW] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_d = sum[OUTW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign out = acc_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: accepts a job length, streams K operand pairs into one mac, returns the sum.
// Optional stall counter output enabled by defining MAC_SEQ_STALL_CNT_EN.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter  int unsigned INW  = INW_DEF,
  parameter  int unsigned OUTW = OUTW_DEF,
  parameter  int unsigned MAXK = MAXK_DEF,
  localparam int unsigned KW   = $clog2(MAXK + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [KW-1:0]   cfg_k,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [INW-1:0]  in_a,
  input  logic [INW-1:0]  in_b,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [OUTW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef MAC_SEQ_STALL_CNT_EN
  output logic [15:0]     stall_cnt,
`endif
  output logic            busy
);

  localparam logic [KW-1:0] MAXK_K = KW'(MAXK);

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic          clear_acc;
  logic          mac_valid;
  logic          mac_rst;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    clear_acc = 1'b0;
    mac_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Held low while reset is asserted even though the state already reads IDLE.
        cfg_ready = reset;
        if (cfg_valid && reset) begin
          k_d       = (cfg_k > MAXK_K) ? MAXK_K : cfg_k;
          cnt_d     = '0;
          clear_acc = 1'b1;
          state_d   = (cfg_k == '0) ? OUT : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mac_valid = 1'b1;
          cnt_d     = cnt_q + KW'(1);
          if (cnt_q == k_q - KW'(1)) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign mac_rst = ~reset;

  mac #(
    .INW (INW),
    .OUTW(OUTW)
  ) u_mac (
    .clk        (clk),
    .reset      (mac_rst),
    .in0        (in_a),
    .in1        (in_b),
    .valid_input(mac_valid),
    .clear_acc  (clear_acc),
    .out        (out_data)
  );

`ifdef MAC_SEQ_STALL_CNT_EN
  logic        cfg_fire;
  logic [15:0] stall_q, stall_d;

  assign cfg_fire = cfg_ready & cfg_valid;

  always_comb begin
    stall_d = stall_q;
    if (cfg_fire) begin
      stall_d = '0;
    end else if ((state_q == ACCUM) && !in_valid && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl; checks stall_cnt when MAC_SEQ_STALL_CNT_EN is defined.
module tb_mac_seq_ctrl;

  localparam int INW  = 16;
  localparam int OUTW = 32;
  localparam int MAXK = 64;
  localparam int KW   = $clog2(MAXK + 1);
  localparam longint ACC_MAX = 2147483647;
  localparam longint ACC_MIN = -ACC_MAX - 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [KW-1:0]   cfg_k;
  logic            cfg_valid, cfg_ready;
  logic [INW-1:0]  in_a, in_b;
  logic            in_valid, in_ready;
  logic [OUTW-1:0] out_data;
  logic            out_valid, out_ready, busy;
`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0]     stall_cnt;
  logic [15:0]     stall_seen;
`endif

  int checks = 0;
  int errors = 0;
  int opa[128];
  int opb[128];

  always #5 clk = ~clk;

  mac_seq_ctrl #(
    .INW (INW),
    .OUTW(OUTW),
    .MAXK(MAXK)
  ) dut (
    .clk      (clk),
    .reset    (reset_n),
    .cfg_k    (cfg_k),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef MAC_SEQ_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .busy     (busy)
  );

  // Reference: clamp the running sum after every product, over min(k, MAXK) pairs.
  function automatic longint model_dot(input int k);
    longint acc = 0;
    int n = (k > MAXK) ? MAXK : k;
    for (int i = 0; i < n; i++) begin
      acc += longint'(opa[i]) * longint'(opb[i]);
      if (acc > ACC_MAX) acc = ACC_MAX;
      else if (acc < ACC_MIN) acc = ACC_MIN;
    end
    return acc;
  endfunction

  function automatic int rand_op();
    int r = int'($urandom_range(0, 5));
    if (r == 0) return 32767;
    if (r == 1) return -32768;
    return int'($signed(16'($urandom)));
  endfunction

  // Runs one job: gap idle cycles between beats, odly cycles of out_ready low in OUT.
  task automatic run_job(input int k, input int gap, input int odly,
                         output longint res, output int beats, output int irc,
                         output int lat, output bit tmo, output bit bad_out);
    int cyc;
    int g;
    res = 0; beats = 0; irc = 0; lat = 0; tmo = 1'b0; bad_out = 1'b0;
    @(negedge clk);
    cfg_k = KW'(k);
    cfg_valid = 1'b1;
    cyc = 0;
    while (!cfg_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!cfg_ready) begin
      cfg_valid = 1'b0;
      tmo = 1'b1;
      return;
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    lat = 1;
    cyc = 0;
    g = 0;
    while (!out_valid && cyc < 5000) begin
      if (in_ready) begin
        irc++;
        if (g > 0) begin
          in_valid = 1'b0;
          g--;
        end else begin
          in_valid = 1'b1;
          in_a = 16'(opa[beats % 128]);
          in_b = 16'(opb[beats % 128]);
          beats++;
          g = gap;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      tmo = 1'b1;
      return;
    end
    res = longint'($signed(out_data));
`ifdef MAC_SEQ_STALL_CNT_EN
    stall_seen = stall_cnt;
`endif
    for (int i = 0; i <= odly; i++) begin
      out_ready = (i == odly);
      if (!out_valid || longint'($signed(out_data)) != res || in_ready || cfg_ready)
        bad_out = 1'b1;
`ifdef MAC_SEQ_STALL_CNT_EN
      if (stall_cnt != stall_seen) bad_out = 1'b1;
`endif
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cfg_k = '0; cfg_valid = 1'b0;
    in_a = '0; in_b = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cfg_ready, in_ready, out_valid, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got cfg_ready/in_ready/out_valid/busy=%b, want 0000",
               {cfg_ready, in_ready, out_valid, busy});
    end
`ifdef MAC_SEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt: got %0d, want 0", stall_cnt);
    end
`endif
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_data !== '0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got out_data=%0d cfg_ready=%b, want 0 and 1", out_data, cfg_ready);
    end
  endtask

  task automatic test_basic();
    longint res; int beats, irc, lat; bit tmo, bad;
    opa[0] = 2;  opb[0] = 3;
    opa[1] = -4; opb[1] = 5;
    opa[2] = 7;  opb[2] = 7;
    run_job(3, 0, 0, res, beats, irc, lat, tmo, bad);
    checks++;
    if (tmo || res != 35) begin
      errors++;
      $display("FAIL basic_result: got %0d (timeout=%b), want 35", res, tmo);
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles to out_valid, want 4", lat);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_after: got %b, want 0", busy);
    end
  endtask

  task automatic test_stall();
    longint res; int beats, irc, lat; bit tmo, bad;
    for (int i = 0; i < 4; i++) begin
      opa[i] = 1; opb[i] = 1;
    end
    run_job(4, 2, 5, res, beats, irc, lat, tmo, bad);
    checks++;
    if (tmo || res != 4 || beats != 4) begin
      errors++;
      $display("FAIL stall_result: got %0d over %0d beats, want 4 over 4", res, beats);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stall_out_hold: got unstable output or ready high during OUT, want held");
    end
`ifdef MAC_SEQ_STALL_CNT_EN
    checks++;
    if (stall_seen !== 16'd6) begin
      errors++;
      $display("FAIL stall_cnt: got %0d, want 6", stall_seen);
    end
`endif
  endtask

  task automatic test_saturation();
    longint res; int beats, irc, lat; bit tmo, bad;
    for (int i = 0; i < 3; i++) begin
      opa[i] = 32767; opb[i] = 32767;
    end
    run_job(3, 0, 0, res, beats, irc, lat, tmo, bad);
    checks++;
    if (tmo || res != ACC_MAX) begin
      errors++;
      $display("FAIL sat_pos: got %0d, want %0d", res, ACC_MAX);
    end
    for (int i = 0; i < 3; i++) begin
      opa[i] = -32768; opb[i] = 32767;
    end
    run_job(3, 0, 0, res, beats, irc, lat, tmo, bad);
    checks++;
    if (tmo || res != ACC_MIN) begin
      errors++;
      $display("FAIL sat_neg: got %0d, want %0d", res, ACC_MIN);
    end
  endtask

  task automatic test_k_bounds();
    longint res, exp; int beats, irc, lat; bit tmo, bad;
    run_job(0, 0, 0, res, beats, irc, lat, tmo, bad);
    checks++;
    if (tmo || res != 0 || lat != 1 || irc != 0) begin
      errors++;
      $display("FAIL k_zero: got data=%0d latency=%0d in_ready_cycles=%0d, want 0/1/0", res, lat, irc);
    end
    for (int i = 0; i < 128; i++) begin
      opa[i] = int'($signed(16'($urandom)));
      opb[i] = int'($signed(16'($urandom)));
    end
    exp = model_dot(MAXK + 5);
    run_job(MAXK + 5, 0, 0, res, beats, irc, lat, tmo, bad);
    checks++;
    if (tmo || beats != MAXK || irc != MAXK) begin
      errors++;
      $display("FAIL k_clamp_beats: got %0d beats, %0d in_ready cycles, want %0d", beats, irc, MAXK);
    end
    checks++;
    if (res != exp) begin
      errors++;
      $display("FAIL k_clamp_result: got %0d, want %0d", res, exp);
    end
  endtask

  task automatic test_reset_mid_job();
    longint res; int beats, irc, lat, cyc; bit tmo, bad;
    @(negedge clk);
    cfg_k = KW'(5);
    cfg_valid = 1'b1;
    cyc = 0;
    while (!cfg_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = 16'(100); in_b = 16'(100);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b000) begin
      errors++;
      $display("FAIL midjob_reset: got out_valid/in_ready/busy=%b, want 000", {out_valid, in_ready, busy});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    opa[0] = 3; opb[0] = -3;
    run_job(1, 0, 0, res, beats, irc, lat, tmo, bad);
    checks++;
    if (tmo || res != -9 || beats != 1) begin
      errors++;
      $display("FAIL midjob_next: got %0d over %0d beats, want -9 over 1", res, beats);
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[2];
    int out_cyc[2];
    longint res[2];
    int na, no, idx, cyc;
    opa[0] = 1; opb[0] = 2;
    opa[1] = 3; opb[1] = 4;
    opa[2] = 5; opb[2] = 5;
    opa[3] = 1; opb[3] = 1;
    na = 0; no = 0; idx = 0; cyc = 0;
    acc_cyc = '{0, 0}; out_cyc = '{0, 0}; res = '{0, 0};
    cfg_k = KW'(2);
    out_ready = 1'b1;
    while (no < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      cfg_valid = (na < 2);
      if (cfg_valid && cfg_ready) begin
        acc_cyc[na] = cyc;
        na++;
      end
      if (in_ready && idx < 4) begin
        in_valid = 1'b1;
        in_a = 16'(opa[idx]);
        in_b = 16'(opb[idx]);
        idx++;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        res[no] = longint'($signed(out_data));
        out_cyc[no] = cyc;
        no++;
      end
    end
    @(negedge clk);
    cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (no != 2 || res[0] != 14 || res[1] != 26) begin
      errors++;
      $display("FAIL b2b_results: got %0d results %0d,%0d, want 2 results 14,26", no, res[0], res[1]);
    end
    checks++;
    if (acc_cyc[1] != out_cyc[0] + 1) begin
      errors++;
      $display("FAIL b2b_gap: got second accept at cycle %0d, want %0d", acc_cyc[1], out_cyc[0] + 1);
    end
  endtask

  task automatic test_random();
    longint res, exp; int beats, irc, lat, k, gap, odly, n; bit tmo, bad;
    for (int j = 0; j < 12; j++) begin
      k = int'($urandom_range(0, 12));
      gap = int'($urandom_range(0, 2));
      odly = int'($urandom_range(0, 3));
      for (int i = 0; i < 128; i++) begin
        opa[i] = rand_op();
        opb[i] = rand_op();
      end
      exp = model_dot(k);
      n = (k > MAXK) ? MAXK : k;
      run_job(k, gap, odly, res, beats, irc, lat, tmo, bad);
      checks++;
      if (tmo || res != exp || beats != n || bad) begin
        errors++;
        $display("FAIL random_job%0d: k=%0d got %0d over %0d beats (hold_err=%b), want %0d over %0d",
                 j, k, res, beats, bad, exp, n);
      end
`ifdef MAC_SEQ_STALL_CNT_EN
      checks++;
      if (int'(stall_seen) != ((n > 0) ? gap * (n - 1) : 0)) begin
        errors++;
        $display("FAIL random_stall%0d: got %0d, want %0d", j, stall_seen, (n > 0) ? gap * (n - 1) : 0);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_saturation();
    test_k_bounds();
    test_reset_mid_job();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
